// File: rtl/asic_ioring_arbiter.sv
// Round-robin owner arbiter for the shared padring ctrl/sense ring: drive window, sense sample, guard gap.
// Optional per-requester grant counters are built when ASIC_IORING_ARBITER_STATS_EN is defined.
module asic_ioring_arbiter #(
    parameter int NCTRL = 8,
    parameter int NREQ  = 4,
    parameter int HOLD  = 4,
    parameter int GUARD = 2,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*NCTRL-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [NCTRL-1:0]      ctrl_out,
    output logic                  ctrl_oe,
    input  logic [NCTRL-1:0]      ctrl_in,
    output logic [NCTRL-1:0]      rdata,
    output logic                  done,
    output logic [IW-1:0]         done_id,
    output logic                  busy
`ifdef ASIC_IORING_ARBITER_STATS_EN
    ,
    input  logic                  stats_clr,
    output logic [16*NREQ-1:0]    grant_cnt
`endif
);

    // state | meaning
    // IDLE  | ring undriven, arbitrating req each cycle
    // DRIVE | granted word on the ring for HOLD cycles, sense sampled on the last
    // GUARD | ring undriven turnaround for GUARD cycles
    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GUARD} state_t;

    localparam int MAXC = (HOLD > GUARD) ? HOLD : GUARD;
    localparam int CW   = $clog2(MAXC + 1);

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [IW-1:0]   ptr, win, ptr_nx;
    logic            grant, last_drive;

    // Lowest offset from the pointer wins; scanning downward lets the last hit stand.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] p);
        rr_pick = p;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int j;
            j = int'(p) + k;
            if (j >= NREQ) j -= NREQ;
            if (r[j]) rr_pick = IW'(j);
        end
    endfunction

    assign win    = rr_pick(req, ptr);
    assign ptr_nx = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        grant      = 1'b0;
        last_drive = 1'b0;
        case (state)
            S_IDLE: begin
                if (|req) begin
                    grant    = 1'b1;
                    state_nx = S_DRIVE;
                    cnt_nx   = CW'(HOLD - 1);
                end
            end
            S_DRIVE: begin
                if (cnt == '0) begin
                    last_drive = 1'b1;
                    if (GUARD > 0) begin
                        state_nx = S_GUARD;
                        cnt_nx   = CW'((GUARD > 0) ? GUARD - 1 : 0);
                    end else begin
                        state_nx = S_IDLE;
                    end
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            S_GUARD: begin
                if (cnt == '0) state_nx = S_IDLE;
                else           cnt_nx   = cnt - 1'b1;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            ptr      <= '0;
            gnt      <= '0;
            ctrl_out <= '0;
            rdata    <= '0;
            done     <= 1'b0;
            done_id  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            gnt   <= grant ? (NREQ'(1) << win) : '0;
            done  <= last_drive;
            if (grant) begin
                ctrl_out <= wdata[int'(win)*NCTRL +: NCTRL];
                done_id  <= win;
                ptr      <= ptr_nx;
            end else if (last_drive) begin
                ctrl_out <= '0;
            end
            if (last_drive) rdata <= ctrl_in;
        end
    end

    assign ctrl_oe = (state == S_DRIVE);
    assign busy    = (state != S_IDLE);

`ifdef ASIC_IORING_ARBITER_STATS_EN
    logic [15:0] cnt_r [NREQ];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (!nreset || stats_clr)              cnt_r[i] <= '0;
            else if (gnt[i] && cnt_r[i] != 16'hFFFF) cnt_r[i] <= cnt_r[i] + 16'd1;
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_cnt
        assign grant_cnt[g*16 +: 16] = cnt_r[g];
    end
`endif

endmodule

// File: doc/asic_ioring_arbiter.md
Name: asic_ioring_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared NCTRL-bit padring control/sense ring (ctrlring) that is fed through every analog and digital IO cell.
- Grants one requester (trim, calibration or test engine) exclusive ownership of the ring for a fixed drive window, then samples the ring's sense value back.
- Enforces a guard interval with the ring undriven between owners.
- Sits in the core-side padring controller, between requesters and the ring's core-side tristate driver.

Parameters:
- NCTRL, 8, ctrl ring width in bits.
- NREQ, 4, number of requesters; must be >= 2.
- HOLD, 4, cycles the granted word is driven onto the ring; must be >= 1.
- GUARD, 2, undriven turnaround cycles after each drive window; 0 allowed.

Ports:
- clk  input  1  core clock.
- nreset  input  1  synchronous active-low reset.
- req  input  NREQ  request per requester, level.
- wdata  input  NREQ*NCTRL  ctrl word per requester; slice i is [i*NCTRL +: NCTRL].
- gnt  output  NREQ  one-hot grant pulse.
- ctrl_out  output  NCTRL  word driven to the ring.
- ctrl_oe  output  1  ring driver enable.
- ctrl_in  input  NCTRL  ring sense value.
- rdata  output  NCTRL  sampled sense value.
- done  output  1  one-cycle completion pulse.
- done_id  output  $clog2(NREQ)  index of the completed requester.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on nreset.
- Reset values: state=IDLE; gnt=0; ctrl_out=0; ctrl_oe=0; rdata=0; done=0; done_id=0; busy=0; round-robin pointer=0, so requester 0 has highest priority.
- Reset mid-operation: reset asserted in any state aborts the transaction; no done pulse; all outputs return to reset values the cycle after the sampling edge.
- State IDLE:
  - Evaluates req each cycle.
  - If any bit is set, picks the first set bit searching upward from pointer, wrapping NREQ-1 to 0.
  - Latches wdata of the winner into ctrl_out, sets the pointer to winner+1 (mod NREQ), and moves to DRIVE.
  - No request: stays in IDLE with all outputs at reset values; ctrl_out holds 0.
- State DRIVE:
  - Lasts exactly HOLD cycles; ctrl_oe=1 and ctrl_out is stable throughout.
  - gnt[winner]=1 in the first DRIVE cycle only.
  - On the last DRIVE cycle, ctrl_in is registered into rdata; rdata holds until the next sample or reset.
  - Then moves to GUARD, or to IDLE if GUARD=0.
- State GUARD:
  - Lasts GUARD cycles with ctrl_oe=0 and ctrl_out=0, then moves to IDLE.
- done and done_id:
  - done=1 for one cycle, on the first cycle after DRIVE, whether that cycle is GUARD or IDLE.
  - done_id is registered at grant and holds until the next grant.
- Timing:
  - req high at cycle t -> gnt at t+1; ctrl_oe high t+1..t+HOLD; done at t+HOLD+1.
  - IDLE is always occupied for at least one cycle, so back-to-back grants are spaced HOLD+GUARD+1 cycles apart.
- Requester rule:
  - Deassert req in the cycle after gnt is seen.
  - req is ignored outside IDLE; HOLD>=1 guarantees the drop lands before the next arbitration.
- Simultaneous requests: resolved strictly by the rotating pointer; no requester is skipped twice.
- Counters are sized $clog2(max(HOLD,GUARD)+1) and never wrap past their terminal value.

Optional Feature:
- Macro: ASIC_IORING_ARBITER_STATS_EN.
- When defined, adds:
  - Output grant_cnt, width 16*NREQ: per-requester grant counters, incremented on each gnt pulse and saturating at 16'hFFFF.
  - Input stats_clr, width 1: synchronous clear of all counters; has priority over a same-cycle increment.
  - Reset value of all counters is 0.
- When undefined, neither port exists and no counter logic is built.

Test Plan:
- Single request, defaults: req=4'b0100 at t, wdata slice2=8'hA5, ctrl_in=8'h3C -> gnt=4'b0100 at t+1; ctrl_oe high t+1..t+4 with ctrl_out=8'hA5; done at t+5 with done_id=2 and rdata=8'h3C; ctrl_oe=0 during t+5..t+6.
- All four requesting continuously from reset -> grant order 0,1,2,3,0; grants spaced 7 cycles apart.
- GUARD=0, HOLD=1, req=4'b0011 -> gnt[0] at t+1, done at t+2, gnt[1] at t+3; ctrl_oe never overlaps between owners.
- nreset low during the 2nd DRIVE cycle -> next cycle ctrl_oe=0, ctrl_out=0, busy=0; no done pulse; the next request from requester 3 with requester 0 also requesting grants 0 first.
- Pointer wrap: after a grant to requester 3, req=4'b1001 -> requester 0 granted.
- STATS_EN: 70000 grants to requester 1 -> grant_cnt slice1 = 16'hFFFF; stats_clr pulsed -> all slices 0 the next cycle.
